pipe_out_arbiter: RTL and testbench



---
 rtl/pipe_arb_pkg.sv | 39 +++
 rtl/rr_pick.sv | 24 ++
 rtl/pipe_out_arbiter.sv | 149 ++++++++++++++
 tb/tb_pipe_out_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_arb_pkg.sv
// Shared types and helpers for the pipe endpoint arbiters.
// Holds the arbiter state enum, parameter defaults and the round-robin
// search function used by rr_pick.
package pipe_arb_pkg;

  localparam int NSRC_DEF        = 4;
  localparam int BLOCK_WORDS_DEF = 256;
  localparam int MAX_SRC         = 8;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    XFER
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // Search req starting at (last+1) mod n, wrapping; the first set bit wins.
  function automatic pick_t rr_next(input logic [MAX_SRC-1:0] req,
                                    input logic [2:0]         last,
                                    input int                 n = MAX_SRC);
    pick_t p;
    int    cand;
    p = '0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      cand = int'(last) + k;
      if (cand >= n) cand = cand - n;
      if (k <= n && !p.valid && req[3'(cand)]) begin
        p.valid = 1'b1;
        p.idx   = 3'(cand);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: request vector plus index of
// the last winner in, first requester after it (wrapping) out.
module rr_pick
  import pipe_arb_pkg::*;
#(
  parameter int N = NSRC_DEF
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  output logic         valid,
  output logic [2:0]   idx
);

  pick_t pick;

  // Widen the request vector to the helper's fixed width and search it.
  always_comb begin
    pick = rr_next(MAX_SRC'(req), last, N);
  end

  assign valid = pick.valid;
  assign idx   = pick.idx;

endmodule

// File: rtl/pipe_out_arbiter.sv
// Round-robin block scheduler in front of a block-throttled pipe-out
// endpoint. A source is granted only when it holds a full block; the grant
// lasts exactly BLOCK_WORDS reads, then the pipe is released.
// Optional feature: define PIPE_ARB_STATS_EN to add per-source saturating
// completed-block counters on output blk_count.
module pipe_out_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NSRC        = NSRC_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int CNTW        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*CNTW-1:0] src_count,
  input  logic [NSRC*16-1:0]   src_data,
  output logic [NSRC-1:0]      src_pop,
  output logic                 ep_ready,
  input  logic                 ep_blockstrobe,
  input  logic                 ep_read,
  output logic [15:0]          ep_datain,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 proto_err
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [NSRC*16-1:0]   blk_count
`endif
);

  localparam int              CW        = $clog2(BLOCK_WORDS);
  localparam logic [CW-1:0]   LAST_WORD = CW'(BLOCK_WORDS - 1);
  localparam logic [CNTW-1:0] THRESH    = CNTW'(BLOCK_WORDS);

  arb_state_t      state;
  logic [2:0]      last_grant;
  logic [CW-1:0]   word_cnt;
  logic [NSRC-1:0] req;
  logic            pick_valid;
  logic [2:0]      pick_idx;
  logic            xfer_read;
  logic            terminal;

  // A source requests once it holds at least one full block.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    req = '0;
    for (int i = 0; i < NSRC; i++) begin
      req[i] = (src_count[i*CNTW +: CNTW] >= THRESH);
    end
  end

  rr_pick #(.N(NSRC)) u_pick (
    .req   (req),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign xfer_read = (state == XFER) && ep_read;
  assign terminal  = xfer_read && (word_cnt == LAST_WORD);

  // Zero-latency read strobe to the granted FIFO and data mux off grant_id.
  always_comb begin
    src_pop   = '0;
    ep_datain = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_pop[i] = xfer_read && (grant_id == 3'(i));
      if (grant_id == 3'(i)) ep_datain = src_data[i*16 +: 16];
    end
  end

  // Arbitration FSM with registered ep_ready/busy and sticky protocol flag.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      ep_ready   <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
      grant_id   <= '0;
      last_grant <= 3'(NSRC - 1);
      word_cnt   <= '0;
    end else begin
      if (ep_read && state != XFER)         proto_err <= 1'b1;
      if (ep_blockstrobe && state != READY) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            state    <= READY;
            ep_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        READY: begin
          if (ep_blockstrobe) begin
            state    <= XFER;
            word_cnt <= '0;
            ep_ready <= 1'b0;
          end
        end
        XFER: begin
          if (ep_read) begin
            if (word_cnt == LAST_WORD) begin
              state      <= IDLE;
              busy       <= 1'b0;
              last_grant <= grant_id;
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_ARB_STATS_EN
  logic [15:0] blk_cnt [NSRC];

  // Count completed blocks per source, saturating at all-ones.
  always_ff @(posedge clk) begin
    // NOTE: this is a small flop array, not a RAM, so resetting every entry
    // is legitimate and keeps the counters deterministic.
    if (reset) begin
      for (int i = 0; i < NSRC; i++) blk_cnt[i] <= '0;
    end else if (terminal) begin
      for (int i = 0; i < NSRC; i++) begin
        if (grant_id == 3'(i) && blk_cnt[i] != 16'hFFFF)
          blk_cnt[i] <= blk_cnt[i] + 16'd1;
      end
    end
  end

  // Pack the counters onto the output bus, field i at bits [i*16 +: 16].
  always_comb begin
    blk_count = '0;
    for (int i = 0; i < NSRC; i++) blk_count[i*16 +: 16] = blk_cnt[i];
  end
`else
  // Terminal-read decode only feeds the statistics counters.
  logic unused_terminal;
  assign unused_terminal = terminal;
`endif

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Directed self-checking bench for pipe_out_arbiter (NSRC=4, 256-word
// blocks). A tiny FIFO model supplies per-source data that advances on pops.
module tb_pipe_out_arbiter;

  localparam int NSRC = 4;
  localparam int BW   = 256;
  localparam int CNTW = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NSRC*CNTW-1:0] src_count;
  logic [NSRC*16-1:0]   src_data;
  logic [NSRC-1:0]      src_pop;
  logic                 ep_ready;
  logic                 ep_blockstrobe = 1'b0;
  logic                 ep_read = 1'b0;
  logic [15:0]          ep_datain;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 proto_err;
`ifdef PIPE_ARB_STATS_EN
  logic [NSRC*16-1:0]   blk_count;
`endif

  logic [15:0] cnt [NSRC];
  logic [15:0] ptr [NSRC] = '{default: 16'd0};
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_out_arbiter #(.NSRC(NSRC), .BLOCK_WORDS(BW), .CNTW(CNTW)) dut (
    .clk            (clk),
    .reset          (reset),
    .src_count      (src_count),
    .src_data       (src_data),
    .src_pop        (src_pop),
    .ep_ready       (ep_ready),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_read        (ep_read),
    .ep_datain      (ep_datain),
    .grant_id       (grant_id),
    .busy           (busy),
    .proto_err      (proto_err)
`ifdef PIPE_ARB_STATS_EN
    ,
    .blk_count      (blk_count)
`endif
  );

  // FIFO model: read pointer advances on each pop, data = source tag + pointer.
  always @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) if (src_pop[i]) ptr[i] <= ptr[i] + 16'd1;
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_count[i*CNTW +: CNTW] = cnt[i];
      src_data[i*16 +: 16]      = 16'((i + 1) * 4096) + ptr[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    cnt[0] = 16'(c0); cnt[1] = 16'(c1); cnt[2] = 16'(c2); cnt[3] = 16'(c3);
  endtask

  task automatic do_reset();
    reset = 1'b1; ep_read = 1'b0; ep_blockstrobe = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Wait for a grant, check its index, strobe and issue nreads reads.
  task automatic do_block(input int id, input int nreads);
    int              w;
    int              pop_bad;
    int              data_bad;
    logic [15:0]     start;
    logic [NSRC-1:0] exp_pop;
    w = 0; pop_bad = 0; data_bad = 0;
    while (!ep_ready && w < 16) begin tick(); w++; end
    check("ready_wait", ep_ready, 1);
    check("grant_id", grant_id, id);
    start   = ptr[id];
    exp_pop = NSRC'(1 << id);
    ep_blockstrobe = 1'b1; tick(); ep_blockstrobe = 1'b0;
    check("ready_drop", ep_ready, 0);
    check("busy_xfer", busy, 1);
    for (int k = 0; k < nreads; k++) begin
      ep_read = 1'b1;
      #1;
      if (src_pop !== exp_pop) pop_bad++;
      if (ep_datain !== 16'((id + 1) * 4096) + start + 16'(k)) data_bad++;
      tick();
    end
    ep_read = 1'b0;
    check("pop_pattern_errs", pop_bad, 0);
    check("datain_errs", data_bad, 0);
    if (nreads == BW) begin
      check("idle_busy", busy, 0);
      check("idle_ready", ep_ready, 0);
    end
  endtask

  initial begin
    // Reset state, then single-source grant and one full block.
    set_counts(0, 0, 256, 0);
    reset = 1'b1; tick(); tick();
    check("rst_ready", ep_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_proto", proto_err, 0);
    check("rst_grant", grant_id, 0);
    check("rst_pop", src_pop, 0);
    check("rst_datain", ep_datain, 16'h1000);
    reset = 1'b0;
    tick();
    check("t1_ready", ep_ready, 1);
    check("t1_grant", grant_id, 2);
    do_block(2, BW);
    cnt[2] = 16'd0;
    tick();
    check("t1_gap_ready", ep_ready, 0);
    check("t1_proto", proto_err, 0);

    // All sources full: grant order 0,1,2,3,0,1,2,3.
    set_counts(1000, 1000, 1000, 1000);
    do_reset();
    for (int b = 0; b < 8; b++) do_block(b % NSRC, BW);
    check("t2_proto", proto_err, 0);

    // 255 words is not a block; 256 is.
    set_counts(0, 255, 0, 0);
    do_reset();
    repeat (3) tick();
    check("t3_below", ep_ready, 0);
    cnt[1] = 16'd256;
    tick();
    check("t3_ready", ep_ready, 1);
    check("t3_grant", grant_id, 1);

    // Read in IDLE: error flag, no pop, state kept; flag is sticky.
    set_counts(0, 0, 0, 0);
    do_reset();
    tick();
    ep_read = 1'b1;
    #1 check("t4_idle_pop", src_pop, 0);
    tick();
    ep_read = 1'b0;
    check("t4_proto", proto_err, 1);
    check("t4_busy", busy, 0);
    repeat (4) tick();
    check("t4_sticky", proto_err, 1);
    do_reset();
    check("t4_clear", proto_err, 0);
    ep_blockstrobe = 1'b1; tick(); ep_blockstrobe = 1'b0;
    check("t4_strobe_idle", proto_err, 1);
    check("t4_strobe_busy", busy, 0);

    // Strobe plus read in READY: strobe honoured, read flagged.
    set_counts(0, 0, 0, 256);
    do_reset();
    tick();
    check("t4_ready3", ep_ready, 1);
    ep_blockstrobe = 1'b1; ep_read = 1'b1;
    #1 check("t4_ready_pop", src_pop, 0);
    tick();
    ep_blockstrobe = 1'b0; ep_read = 1'b0;
    check("t4_xfer_busy", busy, 1);
    check("t4_xfer_ready", ep_ready, 0);
    check("t4_both_proto", proto_err, 1);

    // Reset mid-block: abandon, then search restarts at source 0.
    set_counts(256, 256, 0, 0);
    do_reset();
    do_block(0, BW);
    do_block(1, 100);
    reset = 1'b1;
    tick();
    check("t5_ready", ep_ready, 0);
    check("t5_busy", busy, 0);
    ep_read = 1'b1;
    #1 check("t5_pop", src_pop, 0);
    ep_read = 1'b0;
    reset = 1'b0;
    tick();
    check("t5_regrant", ep_ready, 1);
    check("t5_grant0", grant_id, 0);
    check("t5_proto", proto_err, 0);

`ifdef PIPE_ARB_STATS_EN
    // Three blocks from source 1 are counted in field 1 only.
    set_counts(0, 256, 0, 0);
    do_reset();
    check("st_reset", blk_count, 0);
    repeat (3) do_block(1, BW);
    check("st_count", blk_count, 64'h0000_0000_0003_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
